// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared constants and types for the multi-cycle sequencer
package mc_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [3:0] {
        CLS_OP,
        CLS_OPIMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILL
    } op_class_e;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode class decode and legality check
module mc_decode
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class,
    output logic       illegal
);

    // Every legal opcode ends in 2'b11, so compressed encodings fall to default.
    always_comb begin
        case (opcode)
            OPC_OP:     op_class = CLS_OP;
            OPC_OPIMM:  op_class = CLS_OPIMM;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE:  op_class = CLS_STORE;
            OPC_BRANCH: op_class = CLS_BRANCH;
            OPC_JAL:    op_class = CLS_JAL;
            OPC_JALR:   op_class = CLS_JALR;
            OPC_LUI:    op_class = CLS_LUI;
            OPC_AUIPC:  op_class = CLS_AUIPC;
            default:    op_class = CLS_ILL;
        endcase
    end

    assign illegal = (op_class == CLS_ILL);

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle RV32I control FSM with handshaked memory; SEQ_PERF_EN adds counters
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            clr,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_addr_sel,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] alu_out,
    input  logic            branch_taken,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] old_pc,
    output logic [31:0]     ir,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            alu_func_sel,
    output logic            reg_we,
    output logic [1:0]      wb_sel,
`ifdef SEQ_PERF_EN
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt,
`endif
    output logic            halted
);

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [XLEN-1:0] pc_next;
    logic            ir_load;
    op_class_e       op_class;
    logic            illegal;

    mc_decode u_decode (
        .opcode   (ir[6:0]),
        .op_class (op_class),
        .illegal  (illegal)
    );

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_load    = 1'b0;
        case (state)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_next    = pc + XLEN'(4);
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: state_next = illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                case (op_class)
                    CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC: state_next = ST_WB;
                    CLS_LOAD, CLS_STORE:                   state_next = ST_MEM;
                    CLS_BRANCH: begin
                        state_next = ST_FETCH;
                        if (branch_taken) begin
                            pc_next    = alu_out;
                            state_next = misaligned(alu_out[1:0]) ? ST_TRAP : ST_FETCH;
                        end
                    end
                    CLS_JAL: begin
                        pc_next    = alu_out;
                        state_next = misaligned(alu_out[1:0]) ? ST_TRAP : ST_WB;
                    end
                    CLS_JALR: begin
                        pc_next    = alu_result & ~{{(XLEN-1){1'b0}}, 1'b1};
                        state_next = misaligned({alu_result[1], 1'b0}) ? ST_TRAP : ST_WB;
                    end
                    default: state_next = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_next = (op_class == CLS_STORE) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB:   state_next = ST_FETCH;
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            old_pc <= '0;
            ir     <= NOP;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (ir_load) begin
                ir     <= mem_rdata;
                old_pc <= pc;
            end
        end
    end

    // Requests are gated by clr so an in-flight transaction drops the moment reset asserts.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRC_B_RS2;
        alu_func_sel = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        halted       = 1'b0;
        case (state)
            ST_FETCH:  mem_req = clr;
            ST_DECODE: alu_src_b = SRC_B_IMM;
            ST_EXEC: begin
                case (op_class)
                    CLS_OP: begin
                        alu_src_a    = 1'b1;
                        alu_func_sel = 1'b1;
                    end
                    CLS_OPIMM: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = SRC_B_IMM;
                        alu_func_sel = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE, CLS_JALR, CLS_LUI: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_B_IMM;
                    end
                    CLS_BRANCH: begin
                        alu_src_a    = 1'b1;
                        alu_func_sel = 1'b1;
                    end
                    CLS_JAL:   alu_src_b = SRC_B_FOUR;
                    CLS_AUIPC: alu_src_b = SRC_B_IMM;
                    default:   alu_src_b = SRC_B_RS2;
                endcase
            end
            ST_MEM: begin
                mem_req      = clr;
                mem_addr_sel = 1'b1;
                mem_we       = clr && (op_class == CLS_STORE);
            end
            ST_WB: begin
                reg_we = (ir[11:7] != 5'd0);
                if (op_class == CLS_LOAD) begin
                    wb_sel = WB_MEM;
                end else if (op_class == CLS_JAL || op_class == CLS_JALR) begin
                    wb_sel = WB_LINK;
                end
            end
            ST_TRAP: halted = 1'b1;
            default: halted = 1'b1;
        endcase
    end

`ifdef SEQ_PERF_EN
    logic retire;

    // An instruction retires in its final state: WB, a completed store, or a branch's EXEC.
    assign retire = (state == ST_WB)
                 || (state == ST_MEM && mem_ready && op_class == CLS_STORE)
                 || (state == ST_EXEC && op_class == CLS_BRANCH);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != ST_TRAP) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (retire) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - directed scoreboard bench for mc_sequencer
module tb_mc_sequencer;

    localparam int EV_WB = 0;
    localparam int EV_DM = 1;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] val;
    } ev_t;

    logic        clk;
    logic        clr;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic        branch_taken;
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] ir;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        alu_func_sel;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        halted;
`ifdef SEQ_PERF_EN
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    ev_t         exp_q[$];
    logic [31:0] pc_log [64];
    logic [3:0]  sel_log [64];
    logic [31:0] ir_c1;
    int          n_addr1;
    int          n;
    int          nreq;

    mc_sequencer #(
        .XLEN     (32),
        .RESET_PC (32'h100)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .alu_result   (alu_result),
        .alu_out      (alu_out),
        .branch_taken (branch_taken),
        .pc           (pc),
        .old_pc       (old_pc),
        .ir           (ir),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_func_sel (alu_func_sel),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
`ifdef SEQ_PERF_EN
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt),
`endif
        .halted       (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int cyc, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Memory model plus monitor: plays one instruction from its first fetch cycle
    // until the next fetch request (or trap), popping scoreboard events as they occur.
    task automatic run_instr(input logic [31:0] instr, input int fwait, input int dwait,
                             input bit noisy, output int ncyc);
        int  fw_cnt;
        int  dw_cnt;
        int  c;
        bit  fetched;
        bit  done;
        ev_t e;
        fw_cnt    = 0;
        dw_cnt    = 0;
        c         = 1;
        fetched   = 1'b0;
        done      = 1'b0;
        ncyc      = 0;
        n_addr1   = 0;
        mem_rdata = instr;
        while (!done && c <= 40) begin
            if ((mem_req && !mem_addr_sel && fetched) || halted) begin
                ncyc      = c - 1;
                mem_ready = 1'b0;
                done      = 1'b1;
            end else begin
                pc_log[c]  = pc;
                sel_log[c] = {alu_src_a, alu_src_b, alu_func_sel};
                if (c == 1) ir_c1 = ir;
                if (reg_we) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_reg_we", reg_we, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ev_kind_wb", e.kind, EV_WB);
                        check("wb_cycle", c, e.cyc);
                        check("wb_sel", wb_sel, e.val);
                    end
                end
                if (mem_req && !mem_addr_sel) begin
                    mem_ready = (fw_cnt == fwait);
                    fw_cnt++;
                    if (mem_ready) fetched = 1'b1;
                end else if (mem_req) begin
                    n_addr1++;
                    mem_ready = (dw_cnt == dwait);
                    dw_cnt++;
                    if (mem_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_data_req", mem_req, 1'b0);
                        end else begin
                            e = exp_q.pop_front();
                            check("ev_kind_dm", e.kind, EV_DM);
                            check("dm_cycle", c, e.cyc);
                            check("dm_we", mem_we, e.val);
                        end
                    end
                end else begin
                    mem_ready = noisy;
                end
                @(posedge clk);
                #1;
                c++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL timeout instr=%0h observed_cycles=%0d", instr, c);
        end
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        clr          = 1'b0;
        mem_ready    = 1'b0;
        mem_rdata    = 32'h0;
        alu_result   = 32'h0;
        alu_out      = 32'h0;
        branch_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_pc", pc, 32'h100);
        check("rst_old_pc", old_pc, 32'h0);
        check("rst_ir", ir, 32'h13);
        check("rst_reg_we", reg_we, 1'b0);
        check("rst_halted", halted, 1'b0);
`ifdef SEQ_PERF_EN
        check("rst_cycle_cnt", cycle_cnt, 64'd0);
        check("rst_instret", instret_cnt, 64'd0);
`endif
        clr = 1'b1;
        #1;

        // ADDI x1,x0,5, no wait states
        push_ev(EV_WB, 4, 0);
        run_instr(32'h0050_0093, 0, 0, 1'b0, n);
        check("addi_cycles", n, 4);
        check("first_req_pc", pc_log[1], 32'h100);
        check("ir_before_fetch", ir_c1, 32'h13);
        check("pc_after_hs", pc_log[2], 32'h104);
        check("decode_sel", sel_log[2], 4'b0100);
        check("addi_exec_sel", sel_log[3], 4'b1101);

        // ADDI with 3 fetch wait states
        push_ev(EV_WB, 7, 0);
        run_instr(32'h0050_0093, 3, 0, 1'b0, n);
        check("addi_wait_cycles", n, 7);
        check("addi_wait_pc", pc, 32'h108);

        // LW x2,0(x1), 2 data waits
        push_ev(EV_DM, 6, 0);
        push_ev(EV_WB, 7, 1);
        run_instr(32'h0000_A103, 0, 2, 1'b0, n);
        check("lw_cycles", n, 7);
        check("lw_addr_sel_cycles", n_addr1, 3);
        check("lw_exec_sel", sel_log[3], 4'b1100);

        // SW x2,4(x1), 2 data waits
        push_ev(EV_DM, 6, 1);
        run_instr(32'h0020_A223, 0, 2, 1'b0, n);
        check("sw_cycles", n, 6);
        check("sw_addr_sel_cycles", n_addr1, 3);
        check("sw_pc", pc, 32'h110);

        // BEQ taken to 0x200
        alu_out      = 32'h200;
        branch_taken = 1'b1;
        run_instr(32'h0000_0063, 0, 0, 1'b0, n);
        check("beq_t_cycles", n, 3);
        check("beq_t_pc", pc, 32'h200);
        check("beq_t_old_pc", old_pc, 32'h110);
        check("beq_exec_sel", sel_log[3], 4'b1001);

        // BEQ not taken
        branch_taken = 1'b0;
        run_instr(32'h0000_0063, 0, 0, 1'b0, n);
        check("beq_nt_cycles", n, 3);
        check("beq_nt_pc", pc, 32'h204);

        // JAL x1 to 0x300
        alu_out = 32'h300;
        push_ev(EV_WB, 4, 2);
        run_instr(32'h0000_00EF, 0, 0, 1'b0, n);
        check("jal_cycles", n, 4);
        check("jal_pc", pc, 32'h300);

        // NOP writes x0: no reg_we
        run_instr(32'h0000_0013, 0, 0, 1'b0, n);
        check("nop_cycles", n, 4);

        // LUI x3 with mem_ready asserted while idle
        push_ev(EV_WB, 4, 0);
        run_instr(32'h1234_51B7, 0, 0, 1'b1, n);
        check("lui_cycles", n, 4);
        check("lui_next_pc", pc, 32'h308);
        check("lui_next_req", mem_req, 1'b1);
`ifdef SEQ_PERF_EN
        check("instret_9", instret_cnt, 64'd9);
`endif

        // Reset pulsed during a fetch wait
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check("clr_mem_req", mem_req, 1'b0);
        check("clr_pc", pc, 32'h100);
        check("clr_ir", ir, 32'h13);
`ifdef SEQ_PERF_EN
        check("clr_cycle_cnt", cycle_cnt, 64'd0);
        check("clr_instret", instret_cnt, 64'd0);
`endif
        @(posedge clk);
        #1;
        clr = 1'b1;
        #1;

        // JALR to misaligned 0x203 -> pc 0x202 and trap
        alu_result = 32'h203;
        run_instr(32'h0000_80E7, 0, 0, 1'b0, n);
        check("jalr_cycles", n, 3);
        check("jalr_pc", pc, 32'h202);
        check("jalr_halted", halted, 1'b1);
        mem_ready = 1'b1;
        nreq = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (mem_req) nreq++;
        end
        check("trap_no_req", nreq, 0);
        check("trap_sticky", halted, 1'b1);
        check("trap_pc_hold", pc, 32'h202);

        clr = 1'b0;
        @(posedge clk);
        #1;
        check("clr_unhalt", halted, 1'b0);
        clr = 1'b1;
        #1;

        // Illegal opcode 0x7F traps from DECODE
        run_instr(32'h0000_007F, 0, 0, 1'b0, n);
        check("ill_cycles", n, 2);
        check("ill_halted", halted, 1'b1);
        check("ill_pc", pc, 32'h104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
